// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/empty levels,
// optional first-word fall-through output and a synchronous flush.
module param_sync_fifo #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter bit          FWFT       = 1'b0,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must not exceed FIFO_DEPTH");
  end
  if (AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must be below FIFO_DEPTH");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL));
  assign almostempty = !empty && (count_q <= CW'(AE_LEVEL));
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A read from a full FIFO frees the slot the simultaneous write lands in.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_comb begin
    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en && !wr_accept;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr_q];
    assign valid    = !empty;
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q <= '0;
        valid_q    <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_accept;
        if (rd_accept) begin
          data_out_q <= mem[rd_ptr_q];
        end
      end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: three instances (8-deep with custom thresholds,
// 5-deep for wrap, 8-deep FWFT) share stimulus; a queue holds expected words.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;

  logic [15:0] d0, d1, d2;
  logic        v0, ack0, ovf0, udf0, full0, empty0, af0, ae0;
  logic        v1, ack1, ovf1, udf1, full1, empty1, af1, ae1;
  logic        v2, ack2, ovf2, udf2, full2, empty2, af2, ae2;
  logic [3:0]  cnt0, cnt2;
  logic [2:0]  cnt1;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) u0 (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_out(d0), .valid(v0), .wr_ack(ack0), .overflow(ovf0), .underflow(udf0),
    .full(full0), .empty(empty0), .almostfull(af0), .almostempty(ae0), .count(cnt0)
  );

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1'b0)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_out(d1), .valid(v1), .wr_ack(ack1), .overflow(ovf1), .underflow(udf1),
    .full(full1), .empty(empty1), .almostfull(af1), .almostempty(ae1), .count(cnt1)
  );

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) u2 (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_out(d2), .valid(v2), .wr_ack(ack2), .overflow(ovf2), .underflow(udf2),
    .full(full2), .empty(empty2), .almostfull(af2), .almostempty(ae2), .count(cnt2)
  );

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic cyc(input logic w, input logic r, input logic [15:0] d, input logic f);
    wr_en = w; rd_en = r; data_in = d; flush = f;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty0, full0, af0, ae0, v0, ack0, ovf0, udf0, cnt0, d0} !== {8'b1000_0000, 4'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset_fwft0: got e=%b f=%b af=%b ae=%b v=%b ack=%b ovf=%b udf=%b cnt=%0d d=%h, want e=1 others 0",
               empty0, full0, af0, ae0, v0, ack0, ovf0, udf0, cnt0, d0);
    end
    checks++;
    if ({empty2, full2, v2, ack2, ovf2, udf2, cnt2} !== {6'b100000, 4'd0}) begin
      errors++;
      $display("FAIL reset_fwft1: got e=%b f=%b v=%b ack=%b ovf=%b udf=%b cnt=%0d, want e=1 others 0",
               empty2, full2, v2, ack2, ovf2, udf2, cnt2);
    end
  endtask

  // Also covers the AF_LEVEL=6 / AE_LEVEL=2 thresholds on u0.
  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 1'b0);
      sb.push_back(16'(i));
      checks++;
      if (ack0 !== 1'b1 || ovf0 !== 1'b0 || cnt0 !== 4'(i)) begin
        errors++;
        $display("FAIL fill_%0d: got ack=%b ovf=%b cnt=%0d, want ack=1 ovf=0 cnt=%0d", i, ack0, ovf0, cnt0, i);
      end
      checks++;
      if (af0 !== (i >= 6) || ae0 !== (i <= 2)) begin
        errors++;
        $display("FAIL thresh_fill_%0d: got af=%b ae=%b, want af=%b ae=%b", i, af0, ae0, i >= 6, i <= 2);
      end
    end
    checks++;
    if (full0 !== 1'b1) begin
      errors++;
      $display("FAIL full_flag: got %b want 1", full0);
    end
    cyc(1'b1, 1'b0, 16'h0009, 1'b0);
    checks++;
    if (ovf0 !== 1'b1 || ack0 !== 1'b0 || cnt0 !== 4'd8) begin
      errors++;
      $display("FAIL overflow: got ovf=%b ack=%b cnt=%0d, want ovf=1 ack=0 cnt=8", ovf0, ack0, cnt0);
    end
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b1, 16'h0, 1'b0);
      exp_w = sb.pop_front();
      checks++;
      if (v0 !== 1'b1 || d0 !== exp_w || cnt0 !== 4'(i)) begin
        errors++;
        $display("FAIL drain_%0d: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=%0d", i, v0, d0, cnt0, exp_w, i);
      end
      checks++;
      if (af0 !== (i >= 6) || ae0 !== (i >= 1 && i <= 2)) begin
        errors++;
        $display("FAIL thresh_drain_%0d: got af=%b ae=%b, want af=%b ae=%b", i, af0, ae0,
                 i >= 6, i >= 1 && i <= 2);
      end
    end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    checks++;
    if (empty0 !== 1'b1 || udf0 !== 1'b1 || v0 !== 1'b0 || d0 !== 16'h0008) begin
      errors++;
      $display("FAIL underflow: got e=%b udf=%b v=%b d=%h, want e=1 udf=1 v=0 d=0008", empty0, udf0, v0, d0);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (udf0 !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse: got %b want 0", udf0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
      sb.push_back(16'(16'h0100 + i));
    end
    cyc(1'b1, 1'b1, 16'h0055, 1'b0);
    exp_w = sb.pop_front();
    sb.push_back(16'h0055);
    checks++;
    if (ack0 !== 1'b1 || ovf0 !== 1'b0 || cnt0 !== 4'd8 || v0 !== 1'b1 || d0 !== exp_w) begin
      errors++;
      $display("FAIL full_wr_rd: got ack=%b ovf=%b cnt=%0d v=%b d=%h, want ack=1 ovf=0 cnt=8 v=1 d=%h",
               ack0, ovf0, cnt0, v0, d0, exp_w);
    end
    while (sb.size() > 0) begin
      cyc(1'b0, 1'b1, 16'h0, 1'b0);
      exp_w = sb.pop_front();
      checks++;
      if (v0 !== 1'b1 || d0 !== exp_w) begin
        errors++;
        $display("FAIL passthru_drain: got v=%b d=%h, want v=1 d=%h", v0, d0, exp_w);
      end
    end
    cyc(1'b1, 1'b1, 16'h0077, 1'b0);
    checks++;
    if (udf0 !== 1'b1 || cnt0 !== 4'd1 || ack0 !== 1'b1 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL empty_wr_rd: got udf=%b cnt=%0d ack=%b v=%b, want udf=1 cnt=1 ack=1 v=0",
               udf0, cnt0, ack0, v0);
    end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h0077 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL empty_wr_rd_read: got v=%b d=%h e=%b, want v=1 d=0077 e=1", v0, d0, empty0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 1; k <= 3; k++) begin
        cyc(1'b1, 1'b0, 16'(16'hA000 + r * 16 + k), 1'b0);
        sb.push_back(16'(16'hA000 + r * 16 + k));
        checks++;
        if (cnt1 !== 3'(k) || ack1 !== 1'b1) begin
          errors++;
          $display("FAIL wrap_wr_r%0d_k%0d: got cnt=%0d ack=%b, want cnt=%0d ack=1", r, k, cnt1, ack1, k);
        end
      end
      for (int k = 2; k >= 0; k--) begin
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        exp_w = sb.pop_front();
        checks++;
        if (v1 !== 1'b1 || d1 !== exp_w || cnt1 !== 3'(k)) begin
          errors++;
          $display("FAIL wrap_rd_r%0d: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=%0d", r, v1, d1, cnt1, exp_w, k);
        end
      end
    end
  endtask

  task automatic test_fwft_flush();
    do_reset();
    cyc(1'b1, 1'b0, 16'hA5A5, 1'b0);
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'hA5A5 || cnt2 !== 4'd1) begin
      errors++;
      $display("FAIL fwft_first: got v=%b d=%h cnt=%0d, want v=1 d=a5a5 cnt=1", v2, d2, cnt2);
    end
    cyc(1'b1, 1'b0, 16'h5A5A, 1'b0);
    checks++;
    if (d2 !== 16'hA5A5 || cnt2 !== 4'd2) begin
      errors++;
      $display("FAIL fwft_hold: got d=%h cnt=%0d, want d=a5a5 cnt=2", d2, cnt2);
    end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'h5A5A || cnt2 !== 4'd1) begin
      errors++;
      $display("FAIL fwft_pop: got v=%b d=%h cnt=%0d, want v=1 d=5a5a cnt=1", v2, d2, cnt2);
    end
    cyc(1'b1, 1'b0, 16'h1234, 1'b1);
    checks++;
    if (cnt2 !== 4'd0 || empty2 !== 1'b1 || v2 !== 1'b0 || ack2 !== 1'b0) begin
      errors++;
      $display("FAIL fwft_flush: got cnt=%0d e=%b v=%b ack=%b, want cnt=0 e=1 v=0 ack=0", cnt2, empty2, v2, ack2);
    end
    checks++;
    if (d0 !== 16'hA5A5 || v0 !== 1'b0 || cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL reg_flush_hold: got d=%h v=%b cnt=%0d, want d=a5a5 v=0 cnt=0", d0, v0, cnt0);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (cnt2 !== 4'd0 || empty2 !== 1'b1) begin
      errors++;
      $display("FAIL fwft_flush_ignored_wr: got cnt=%0d e=%b, want cnt=0 e=1", cnt2, empty2);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_fwft_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
